// File: rtl/matrix_pkg.sv
// Shared definitions for the LED-matrix frame-buffer writer: opcodes,
// colour-plane bit positions, FSM state encoding and default dimension.
package matrix_pkg;

    localparam int N_DEFAULT = 8;

    localparam logic [1:0] OP_SET_PIX = 2'b00;
    localparam logic [1:0] OP_CLR_PIX = 2'b01;
    localparam logic [1:0] OP_WR_ROW  = 2'b10;
    localparam logic [1:0] OP_CLR_ALL = 2'b11;

    localparam int COL_G = 0;
    localparam int COL_R = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/fb_plane.sv
// One colour plane of the frame buffer: N rows of N bits held in flops.
// A write updates only the bits of row i_row selected by i_mask.
module fb_plane #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_we,
    input  logic [AW-1:0]       i_row,
    input  logic [N-1:0]        i_mask,
    input  logic [N-1:0]        i_data,
    output logic [N-1:0][N-1:0] o_rows
);

    logic [N-1:0][N-1:0] r_rows;

    // Masked read-modify-write of the addressed row.
    // NOTE: the plane is a small flop array rather than a RAM, so it can (and
    // must) be cleared by reset; sequential state always uses <= so every
    // reader sees the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rows <= '0;
        end else if (i_we) begin
            r_rows[i_row] <= (r_rows[i_row] & ~i_mask) | (i_data & i_mask);
        end
    end

    assign o_rows = r_rows;

endmodule

// File: rtl/matrix_fb_writer.sv
// Write-side front end of the 8x8 dual-colour LED matrix. Applies pixel,
// row and clear commands to a green/red frame buffer, serves the row
// scanner through a registered scan port and flags red-on-green collisions.
// Optional build macro FB_DOUBLE_BUFFER_EN adds front/back buffers and a
// swap input; commands target the back buffer, scan and hit read the front.
module matrix_fb_writer
    import matrix_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_x,
    input  logic [AW-1:0] cmd_y,
    input  logic [1:0]    cmd_color,
    input  logic [N-1:0]  cmd_data,
    input  logic [AW-1:0] scan_row,
`ifdef FB_DOUBLE_BUFFER_EN
    input  logic          swap,
`endif
    output logic [N-1:0]  scan_green,
    output logic [N-1:0]  scan_red,
    output logic          busy,
    output logic          hit,
    input  logic          hit_clr
);

    state_t              r_state;
    state_t              w_state_next;
    logic [AW-1:0]       r_clr_row;
    logic                w_accept;
    logic                w_clr_last;
    logic                w_hit_set;
    logic                w_wr_g;
    logic                w_wr_r;
    logic [AW-1:0]       w_wr_row;
    logic [N-1:0]        w_wr_mask;
    logic [N-1:0]        w_wr_data;
    logic [N-1:0]        w_bit;
    logic [N-1:0]        w_g_row;
    logic [N-1:0]        w_r_row;
    logic [N-1:0][N-1:0] w_front_g;
    logic [N-1:0][N-1:0] w_front_r;

    assign w_accept   = cmd_valid & cmd_ready;
    assign w_clr_last = (r_state == ST_CLEAR) && (r_clr_row == AW'(N - 1));
    assign w_bit      = N'(1) << cmd_x;
    assign w_g_row    = w_front_g[cmd_y];
    assign w_r_row    = w_front_r[cmd_y];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next state and handshake outputs; CLEAR lasts exactly N cycles.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && cmd_op == OP_CLR_ALL) w_state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                busy = 1'b1;
                if (w_clr_last) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Row pointer of the clear sweep; wraps back to 0 after row N-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_clr_row <= '0;
        else if (r_state == ST_CLEAR) r_clr_row <= r_clr_row + 1'b1;
    end

    // Decode the accepted command (or the clear sweep) into a masked row write.
    always_comb begin
        w_wr_row  = cmd_y;
        w_wr_mask = '0;
        w_wr_data = '0;
        w_wr_g    = 1'b0;
        w_wr_r    = 1'b0;
        if (r_state == ST_CLEAR) begin
            w_wr_row  = r_clr_row;
            w_wr_mask = '1;
            w_wr_g    = 1'b1;
            w_wr_r    = 1'b1;
        end else if (w_accept) begin
            w_wr_g = cmd_color[COL_G];
            w_wr_r = cmd_color[COL_R];
            case (cmd_op)
                OP_SET_PIX: begin
                    w_wr_mask = w_bit;
                    w_wr_data = '1;
                end
                OP_CLR_PIX: begin
                    w_wr_mask = w_bit;
                end
                OP_WR_ROW: begin
                    w_wr_mask = '1;
                    w_wr_data = cmd_data;
                end
                default: begin
                    w_wr_g = 1'b0;
                    w_wr_r = 1'b0;
                end
            endcase
        end
    end

    // Collision: a colour lands on a pixel lit in the other plane, either
    // already (pre-write front buffer) or by the same two-colour command.
    always_comb begin
        w_hit_set = 1'b0;
        if (w_accept) begin
            case (cmd_op)
                OP_SET_PIX: w_hit_set =
                    (cmd_color[COL_R] & (w_g_row[cmd_x] | cmd_color[COL_G])) |
                    (cmd_color[COL_G] & w_r_row[cmd_x]);
                OP_WR_ROW: w_hit_set =
                    (cmd_color[COL_R] & (|(cmd_data & w_g_row))) |
                    (cmd_color[COL_G] & (|(cmd_data & w_r_row))) |
                    (cmd_color[COL_R] & cmd_color[COL_G] & (|cmd_data));
                default: w_hit_set = 1'b0;
            endcase
        end
    end

    // Sticky collision flag; a new hit beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            hit <= 1'b0;
        else if (w_hit_set) hit <= 1'b1;
        else if (hit_clr)   hit <= 1'b0;
    end

    // Registered scan port, reads the buffer before this edge's write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_green <= '0;
            scan_red   <= '0;
        end else begin
            scan_green <= w_front_g[scan_row];
            scan_red   <= w_front_r[scan_row];
        end
    end

`ifdef FB_DOUBLE_BUFFER_EN
    logic                r_front_sel;
    logic                r_swap_pend;
    logic                r_clr_tgt;
    logic                w_tgt_sel;
    logic [N-1:0][N-1:0] w_g0;
    logic [N-1:0][N-1:0] w_r0;
    logic [N-1:0][N-1:0] w_g1;
    logic [N-1:0][N-1:0] w_r1;

    // The clear sweep keeps targeting the buffer that was back when it began.
    assign w_tgt_sel = (r_state == ST_CLEAR) ? r_clr_tgt : ~r_front_sel;
    assign w_front_g = r_front_sel ? w_g1 : w_g0;
    assign w_front_r = r_front_sel ? w_r1 : w_r0;

    // Buffer swap: immediate in IDLE, deferred to the end of a clear sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_front_sel <= 1'b0;
            r_swap_pend <= 1'b0;
            r_clr_tgt   <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (swap) r_front_sel <= ~r_front_sel;
            if (w_accept && cmd_op == OP_CLR_ALL) r_clr_tgt <= ~r_front_sel;
        end else if (w_clr_last) begin
            if (r_swap_pend || swap) r_front_sel <= ~r_front_sel;
            r_swap_pend <= 1'b0;
        end else if (swap) begin
            r_swap_pend <= 1'b1;
        end
    end

    fb_plane #(.N(N), .AW(AW)) u_green0 (
        .clk(clk), .rst(rst), .i_we(w_wr_g & ~w_tgt_sel), .i_row(w_wr_row),
        .i_mask(w_wr_mask), .i_data(w_wr_data), .o_rows(w_g0)
    );
    fb_plane #(.N(N), .AW(AW)) u_red0 (
        .clk(clk), .rst(rst), .i_we(w_wr_r & ~w_tgt_sel), .i_row(w_wr_row),
        .i_mask(w_wr_mask), .i_data(w_wr_data), .o_rows(w_r0)
    );
    fb_plane #(.N(N), .AW(AW)) u_green1 (
        .clk(clk), .rst(rst), .i_we(w_wr_g & w_tgt_sel), .i_row(w_wr_row),
        .i_mask(w_wr_mask), .i_data(w_wr_data), .o_rows(w_g1)
    );
    fb_plane #(.N(N), .AW(AW)) u_red1 (
        .clk(clk), .rst(rst), .i_we(w_wr_r & w_tgt_sel), .i_row(w_wr_row),
        .i_mask(w_wr_mask), .i_data(w_wr_data), .o_rows(w_r1)
    );
`else
    fb_plane #(.N(N), .AW(AW)) u_green (
        .clk(clk), .rst(rst), .i_we(w_wr_g), .i_row(w_wr_row),
        .i_mask(w_wr_mask), .i_data(w_wr_data), .o_rows(w_front_g)
    );
    fb_plane #(.N(N), .AW(AW)) u_red (
        .clk(clk), .rst(rst), .i_we(w_wr_r), .i_row(w_wr_row),
        .i_mask(w_wr_mask), .i_data(w_wr_data), .o_rows(w_front_r)
    );
`endif

endmodule

// File: tb/tb_matrix_fb_writer.sv
// Directed self-checking bench for matrix_fb_writer (8x8). The
// FB_DOUBLE_BUFFER_EN scenario runs only when that macro is defined.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_matrix_fb_writer;

    localparam logic [1:0] SET = 2'b00;
    localparam logic [1:0] CLR = 2'b01;
    localparam logic [1:0] WRR = 2'b10;
    localparam logic [1:0] CLA = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_x = 3'd0;
    logic [2:0] cmd_y = 3'd0;
    logic [1:0] cmd_color = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic [2:0] scan_row = 3'd0;
    logic [7:0] scan_green;
    logic [7:0] scan_red;
    logic       busy;
    logic       hit;
    logic       hit_clr = 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
    logic       swap = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    matrix_fb_writer #(.N(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_data(cmd_data),
        .scan_row(scan_row),
`ifdef FB_DOUBLE_BUFFER_EN
        .swap(swap),
`endif
        .scan_green(scan_green), .scan_red(scan_red),
        .busy(busy), .hit(hit), .hit_clr(hit_clr)
    );

    // Issue one command at the current falling edge; it is accepted at the
    // next rising edge (block idle) and valid drops at the following fall.
    task automatic send_cmd(input logic [1:0] op, input int x, input int y,
                            input logic [1:0] c, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x[2:0];
        cmd_y     = y[2:0];
        cmd_color = c;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Request a row and return what the scan port shows one cycle later.
    task automatic read_row(input int row, output logic [7:0] g, output logic [7:0] r);
        scan_row = row[2:0];
        @(negedge clk);
        g = scan_green;
        r = scan_red;
    endtask

    task automatic test_reset;
        logic [7:0] g, r;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_row(i, g, r);
            n_checks++;
            if (g !== 8'h00) begin n_fail++; $display("FAIL reset_green row%0d got %h want 00", i, g); end
            n_checks++;
            if (r !== 8'h00) begin n_fail++; $display("FAIL reset_red row%0d got %h want 00", i, r); end
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", hit); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_set_pix;
        logic [7:0] g, r;
        send_cmd(SET, 3, 5, 2'b01, 8'h00);
        read_row(5, g, r);
        n_checks++;
        if (g !== 8'h08) begin n_fail++; $display("FAIL setpix_green got %h want 08", g); end
        n_checks++;
        if (r !== 8'h00) begin n_fail++; $display("FAIL setpix_red got %h want 00", r); end
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL setpix_hit got %b want 0", hit); end
    endtask

    task automatic test_hit;
        logic [7:0] g, r;
        send_cmd(WRR, 0, 2, 2'b01, 8'hC3);
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_green_only got %b want 0", hit); end
        send_cmd(SET, 0, 2, 2'b10, 8'h00);
        n_checks++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_red_on_green got %b want 1", hit); end
        hit_clr = 1'b1;
        @(negedge clk);
        hit_clr = 1'b0;
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_clr got %b want 0", hit); end
        hit_clr = 1'b1;
        send_cmd(WRR, 0, 2, 2'b10, 8'h80);
        hit_clr = 1'b0;
        n_checks++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_set_wins got %b want 1", hit); end
        read_row(2, g, r);
        n_checks++;
        if (g !== 8'hC3) begin n_fail++; $display("FAIL wrrow_green_kept got %h want c3", g); end
        n_checks++;
        if (r !== 8'h80) begin n_fail++; $display("FAIL wrrow_red got %h want 80", r); end
        hit_clr = 1'b1;
        @(negedge clk);
        hit_clr = 1'b0;
    endtask

    task automatic test_pix_ops;
        logic [7:0] g, r;
        send_cmd(CLR, 0, 2, 2'b01, 8'h00);
        send_cmd(WRR, 0, 2, 2'b00, 8'hFF);
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL noop_hit got %b want 0", hit); end
        read_row(2, g, r);
        n_checks++;
        if (g !== 8'hC2) begin n_fail++; $display("FAIL clrpix_green got %h want c2", g); end
        n_checks++;
        if (r !== 8'h80) begin n_fail++; $display("FAIL noop_red got %h want 80", r); end
        send_cmd(SET, 1, 6, 2'b11, 8'h00);
        n_checks++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL same_cmd_hit got %b want 1", hit); end
        read_row(6, g, r);
        n_checks++;
        if (g !== 8'h02 || r !== 8'h02) begin
            n_fail++; $display("FAIL setpix_both got g=%h r=%h want 02/02", g, r);
        end
        hit_clr = 1'b1;
        @(negedge clk);
        hit_clr = 1'b0;
    endtask

    task automatic test_clr_all;
        logic [7:0] g, r;
        int ready_low, busy_high;
        for (int i = 0; i < 8; i++) send_cmd(WRR, 0, i, 2'b11, 8'hFF);
        cmd_valid = 1'b1;
        cmd_op    = CLA;
        ready_low = 0;
        busy_high = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cmd_op    = SET;
                cmd_x     = 3'd0;
                cmd_y     = 3'd0;
                cmd_color = 2'b01;
            end
            if (busy) busy_high++;
            if (cmd_ready) break;
            ready_low++;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (ready_low != 8) begin n_fail++; $display("FAIL clrall_ready_low got %0d want 8", ready_low); end
        n_checks++;
        if (busy_high != 8) begin n_fail++; $display("FAIL clrall_busy_high got %0d want 8", busy_high); end
        for (int i = 0; i < 8; i++) begin
            read_row(i, g, r);
            n_checks++;
            if (g !== 8'h00 || r !== 8'h00) begin
                n_fail++; $display("FAIL clrall_row%0d got g=%h r=%h want 00/00", i, g, r);
            end
        end
    endtask

    task automatic test_reset_in_clear;
        logic [7:0] g, r;
        send_cmd(WRR, 0, 5, 2'b01, 8'h5A);
        send_cmd(WRR, 0, 7, 2'b10, 8'hA5);
        send_cmd(SET, 0, 5, 2'b11, 8'h00);
        scan_row = 3'd5;
        cmd_valid = 1'b1;
        cmd_op    = CLA;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || hit !== 1'b1) begin
            n_fail++; $display("FAIL pre_abort_state got busy=%b hit=%b want 1/1", busy, hit);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || hit !== 1'b0) begin
            n_fail++; $display("FAIL abort_ctrl got ready=%b busy=%b hit=%b want 1/0/0", cmd_ready, busy, hit);
        end
        n_checks++;
        if (scan_green !== 8'h00 || scan_red !== 8'h00) begin
            n_fail++; $display("FAIL abort_scan got g=%h r=%h want 00/00", scan_green, scan_red);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 5; i < 8; i += 2) begin
            read_row(i, g, r);
            n_checks++;
            if (g !== 8'h00 || r !== 8'h00) begin
                n_fail++; $display("FAIL abort_row%0d got g=%h r=%h want 00/00", i, g, r);
            end
        end
        send_cmd(SET, 2, 4, 2'b10, 8'h00);
        read_row(4, g, r);
        n_checks++;
        if (r !== 8'h04 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_abort_idle got r=%h busy=%b want 04/0", r, busy);
        end
    endtask

`ifdef FB_DOUBLE_BUFFER_EN
    task automatic test_double_buffer;
        logic [7:0] g, r;
        int waited;
        send_cmd(SET, 7, 7, 2'b01, 8'h00);
        read_row(7, g, r);
        n_checks++;
        if (g !== 8'h00) begin n_fail++; $display("FAIL db_back_hidden got %h want 00", g); end
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        read_row(7, g, r);
        n_checks++;
        if (g !== 8'h80) begin n_fail++; $display("FAIL db_swap got %h want 80", g); end
        send_cmd(CLA, 0, 0, 2'b00, 8'h00);
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        read_row(7, g, r);
        n_checks++;
        if (g !== 8'h80 || busy !== 1'b1) begin
            n_fail++; $display("FAIL db_swap_deferred got g=%h busy=%b want 80/1", g, busy);
        end
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!cmd_ready) begin n_fail++; $display("FAIL db_clear_timeout got ready=0 want 1"); end
        read_row(7, g, r);
        n_checks++;
        if (g !== 8'h00) begin n_fail++; $display("FAIL db_swap_after_clear got %h want 00", g); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_set_pix();
        test_hit();
        test_pix_ops();
        test_clr_all();
        test_reset_in_clear();
`ifdef FB_DOUBLE_BUFFER_EN
        test_double_buffer();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
